// File: rtl/queue_25_if.sv
// TileLink D-channel beat handshake bundle for the two-entry refill-sink buffer.
// slave is the buffer's view, master is the producer/consumer side.
interface queue_25_if;
  logic        io_enq_valid;
  logic        io_enq_ready;
  logic [2:0]  io_enq_bits_opcode;
  logic [1:0]  io_enq_bits_param;
  logic [2:0]  io_enq_bits_size;
  logic [2:0]  io_enq_bits_source;
  logic [2:0]  io_enq_bits_sink;
  logic        io_enq_bits_denied;
  logic [63:0] io_enq_bits_data;
  logic        io_enq_bits_corrupt;
  logic        io_deq_valid;
  logic        io_deq_ready;
  logic [2:0]  io_deq_bits_opcode;
  logic [1:0]  io_deq_bits_param;
  logic [2:0]  io_deq_bits_size;
  logic [2:0]  io_deq_bits_source;
  logic [2:0]  io_deq_bits_sink;
  logic        io_deq_bits_denied;
  logic [63:0] io_deq_bits_data;
  logic        io_deq_bits_corrupt;

  modport slave (
    input  io_enq_valid, io_enq_bits_opcode, io_enq_bits_param, io_enq_bits_size,
           io_enq_bits_source, io_enq_bits_sink, io_enq_bits_denied,
           io_enq_bits_data, io_enq_bits_corrupt, io_deq_ready,
    output io_enq_ready, io_deq_valid, io_deq_bits_opcode, io_deq_bits_param,
           io_deq_bits_size, io_deq_bits_source, io_deq_bits_sink,
           io_deq_bits_denied, io_deq_bits_data, io_deq_bits_corrupt
  );

  modport master (
    output io_enq_valid, io_enq_bits_opcode, io_enq_bits_param, io_enq_bits_size,
           io_enq_bits_source, io_enq_bits_sink, io_enq_bits_denied,
           io_enq_bits_data, io_enq_bits_corrupt, io_deq_ready,
    input  io_enq_ready, io_deq_valid, io_deq_bits_opcode, io_deq_bits_param,
           io_deq_bits_size, io_deq_bits_source, io_deq_bits_sink,
           io_deq_bits_denied, io_deq_bits_data, io_deq_bits_corrupt
  );
endinterface

// File: rtl/queue_25.sv
// Two-entry non-flow, non-pipe FIFO for TileLink D beats (cache refill sink inbound buffer).
// Optional producer-stability checks under `define QUEUE_25_ASSERT_EN (simulation only).
module queue_25 (
  input logic       clock,
  input logic       reset,
  queue_25_if.slave io
);

  typedef logic [79:0] entry_t;

  entry_t ram_q [2];
  entry_t ram_d [2];
  logic   enq_ptr_q, enq_ptr_d;
  logic   deq_ptr_q, deq_ptr_d;
  logic   maybe_full_q, maybe_full_d;

  logic   ptr_match, empty, full;
  logic   do_enq, do_deq;
  entry_t enq_bits, deq_bits;

  assign enq_bits = {io.io_enq_bits_opcode, io.io_enq_bits_param, io.io_enq_bits_size,
                     io.io_enq_bits_source, io.io_enq_bits_sink, io.io_enq_bits_denied,
                     io.io_enq_bits_data, io.io_enq_bits_corrupt};

  always_comb begin
    ptr_match = (enq_ptr_q == deq_ptr_q);
    empty     = ptr_match & ~maybe_full_q;
    full      = ptr_match & maybe_full_q;
    // Ready/valid come from state alone, so no flow-through or pipe path exists.
    do_enq    = io.io_enq_valid & ~full;
    do_deq    = io.io_deq_ready & ~empty;
    deq_bits  = ram_q[deq_ptr_q];

    ram_d        = ram_q;
    enq_ptr_d    = enq_ptr_q;
    deq_ptr_d    = deq_ptr_q;
    maybe_full_d = maybe_full_q;
    if (do_enq) begin
      ram_d[enq_ptr_q] = enq_bits;
      enq_ptr_d        = ~enq_ptr_q;
    end
    if (do_deq) deq_ptr_d = ~deq_ptr_q;
    if (do_enq != do_deq) maybe_full_d = do_enq;
  end

  assign io.io_enq_ready        = ~full;
  assign io.io_deq_valid        = ~empty;
  assign io.io_deq_bits_opcode  = deq_bits[79:77];
  assign io.io_deq_bits_param   = deq_bits[76:75];
  assign io.io_deq_bits_size    = deq_bits[74:72];
  assign io.io_deq_bits_source  = deq_bits[71:69];
  assign io.io_deq_bits_sink    = deq_bits[68:66];
  assign io.io_deq_bits_denied  = deq_bits[65];
  assign io.io_deq_bits_data    = deq_bits[64:1];
  assign io.io_deq_bits_corrupt = deq_bits[0];

  // Storage carries no reset; only the pointers define occupancy.
  always_ff @(posedge clock) begin
    ram_q <= ram_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      enq_ptr_q    <= 1'b0;
      deq_ptr_q    <= 1'b0;
      maybe_full_q <= 1'b0;
    end else begin
      enq_ptr_q    <= enq_ptr_d;
      deq_ptr_q    <= deq_ptr_d;
      maybe_full_q <= maybe_full_d;
    end
  end

`ifdef QUEUE_25_ASSERT_EN
  property p_enq_stable;
    @(posedge clock) disable iff (reset)
      (io.io_enq_valid && !io.io_enq_ready) |=> (io.io_enq_valid && $stable(enq_bits));
  endproperty

  a_enq_stable: assert property (p_enq_stable)
    else begin
      $error("queue_25: enqueue beat dropped or changed while stalled");
      $fatal(1, "queue_25: producer stability violated");
    end
`else
`endif

endmodule

// File: tb/tb_queue_25.sv
// Self-checking bench for queue_25: directed scenarios plus randomized traffic
// compared against a SystemVerilog-queue occupancy model.
module tb_queue_25;

  logic        clock;
  logic        reset;
  logic        enq_v;
  logic        deq_r;
  logic [79:0] enq_bits;
  logic [79:0] deq_bits;
  logic [79:0] mq[$];
  int          checks;
  int          errors;

  queue_25_if io ();

  queue_25 u_dut (
    .clock (clock),
    .reset (reset),
    .io    (io)
  );

  assign io.io_enq_valid        = enq_v;
  assign io.io_deq_ready        = deq_r;
  assign io.io_enq_bits_opcode  = enq_bits[79:77];
  assign io.io_enq_bits_param   = enq_bits[76:75];
  assign io.io_enq_bits_size    = enq_bits[74:72];
  assign io.io_enq_bits_source  = enq_bits[71:69];
  assign io.io_enq_bits_sink    = enq_bits[68:66];
  assign io.io_enq_bits_denied  = enq_bits[65];
  assign io.io_enq_bits_data    = enq_bits[64:1];
  assign io.io_enq_bits_corrupt = enq_bits[0];
  assign deq_bits = {io.io_deq_bits_opcode, io.io_deq_bits_param, io.io_deq_bits_size,
                     io.io_deq_bits_source, io.io_deq_bits_sink, io.io_deq_bits_denied,
                     io.io_deq_bits_data, io.io_deq_bits_corrupt};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [79:0] mk(input logic [63:0] data, input logic [2:0] src);
    logic [79:0] b;
    b = {$urandom, $urandom, $urandom};
    b[71:69] = src;
    b[64:1]  = data;
    return b;
  endfunction

  // Advance one clock edge; the model is a plain FIFO of at most two beats.
  task automatic tick();
    logic [79:0] dropped;
    bit en, de;
    @(posedge clock);
    if (reset) mq.delete();
    else begin
      en = enq_v && (mq.size() < 2);
      de = deq_r && (mq.size() > 0);
      if (de) dropped = mq.pop_front();
      if (en) mq.push_back(enq_bits);
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enq_v = 1'b0; deq_r = 1'b0; enq_bits = '0;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) reset = 1'b0;
      tick();
      checks++;
      if (io.io_enq_ready !== 1'b1) begin
        errors++; $display("FAIL reset_enq_ready cyc %0d: got %b want 1", i, io.io_enq_ready);
      end
      checks++;
      if (io.io_deq_valid !== 1'b0) begin
        errors++; $display("FAIL reset_deq_valid cyc %0d: got %b want 0", i, io.io_deq_valid);
      end
    end
  endtask

  task automatic test_ordering();
    deq_r = 1'b0; enq_v = 1'b1;
    enq_bits = mk(64'h11, 3'd1); tick();
    enq_bits = mk(64'h22, 3'd2); tick();
    enq_v = 1'b0;
    checks++;
    if (io.io_enq_ready !== 1'b0 || io.io_deq_valid !== 1'b1) begin
      errors++; $display("FAIL order_full: got rdy=%b vld=%b want rdy=0 vld=1", io.io_enq_ready, io.io_deq_valid);
    end
    checks++;
    if (io.io_deq_bits_data !== 64'h11 || io.io_deq_bits_source !== 3'd1) begin
      errors++; $display("FAIL order_head0: got data=%h src=%0d want 11/1", io.io_deq_bits_data, io.io_deq_bits_source);
    end
    checks++;
    if (deq_bits !== mq[0]) begin
      errors++; $display("FAIL order_head0_fields: got %h want %h", deq_bits, mq[0]);
    end
    deq_r = 1'b1; tick();
    checks++;
    if (io.io_deq_valid !== 1'b1 || io.io_deq_bits_data !== 64'h22 || io.io_deq_bits_source !== 3'd2) begin
      errors++; $display("FAIL order_head1: got vld=%b data=%h src=%0d want 1/22/2", io.io_deq_valid, io.io_deq_bits_data, io.io_deq_bits_source);
    end
    tick();
    checks++;
    if (io.io_deq_valid !== 1'b0 || io.io_enq_ready !== 1'b1) begin
      errors++; $display("FAIL order_empty: got vld=%b rdy=%b want 0/1", io.io_deq_valid, io.io_enq_ready);
    end
    deq_r = 1'b0;
  endtask

  task automatic test_no_flow();
    enq_v = 1'b1; deq_r = 1'b1; enq_bits = mk(64'hAB, 3'd3);
    checks++;
    if (io.io_deq_valid !== 1'b0) begin
      errors++; $display("FAIL noflow_same_cycle: got vld=%b want 0", io.io_deq_valid);
    end
    tick();
    enq_v = 1'b0;
    checks++;
    if (io.io_deq_valid !== 1'b1 || io.io_deq_bits_data !== 64'hAB) begin
      errors++; $display("FAIL noflow_next: got vld=%b data=%h want 1/ab", io.io_deq_valid, io.io_deq_bits_data);
    end
    tick();
    checks++;
    if (io.io_deq_valid !== 1'b0) begin
      errors++; $display("FAIL noflow_drain: got vld=%b want 0", io.io_deq_valid);
    end
    deq_r = 1'b0;
  endtask

  task automatic test_full_stall();
    deq_r = 1'b0; enq_v = 1'b1;
    enq_bits = mk(64'hA0, 3'd4); tick();
    enq_bits = mk(64'hB0, 3'd5); tick();
    enq_bits = mk(64'hC0, 3'd6); deq_r = 1'b1;
    checks++;
    if (io.io_enq_ready !== 1'b0) begin
      errors++; $display("FAIL nopipe_ready: got %b want 0", io.io_enq_ready);
    end
    tick();
    enq_v = 1'b0; deq_r = 1'b0;
    checks++;
    if (io.io_enq_ready !== 1'b1 || io.io_deq_valid !== 1'b1) begin
      errors++; $display("FAIL nopipe_after: got rdy=%b vld=%b want 1/1", io.io_enq_ready, io.io_deq_valid);
    end
    checks++;
    if (io.io_deq_bits_data !== 64'hB0 || deq_bits !== mq[0]) begin
      errors++; $display("FAIL nopipe_head: got %h want %h", deq_bits, mq[0]);
    end
    deq_r = 1'b1; tick();
    checks++;
    if (io.io_deq_valid !== 1'b0) begin
      errors++; $display("FAIL nopipe_drain: got vld=%b want 0 (stalled beat written?)", io.io_deq_valid);
    end
    deq_r = 1'b0;
  endtask

  task automatic test_stream();
    enq_v = 1'b1; deq_r = 1'b1;
    for (int i = 0; i < 10; i++) begin
      enq_bits = mk(64'(i), 3'(i));
      if (i == 0) begin
        checks++;
        if (io.io_deq_valid !== 1'b0) begin
          errors++; $display("FAIL stream_start: got vld=%b want 0", io.io_deq_valid);
        end
      end else begin
        checks++;
        if (io.io_deq_valid !== 1'b1 || io.io_enq_ready !== 1'b1 || io.io_deq_bits_data !== 64'(i - 1)) begin
          errors++; $display("FAIL stream_beat %0d: got vld=%b rdy=%b data=%h want 1/1/%h",
                             i, io.io_deq_valid, io.io_enq_ready, io.io_deq_bits_data, 64'(i - 1));
        end
      end
      tick();
    end
    enq_v = 1'b0;
    checks++;
    if (io.io_deq_valid !== 1'b1 || io.io_deq_bits_data !== 64'd9) begin
      errors++; $display("FAIL stream_last: got vld=%b data=%h want 1/9", io.io_deq_valid, io.io_deq_bits_data);
    end
    tick();
    deq_r = 1'b0;
  endtask

  task automatic test_reset_full();
    deq_r = 1'b0; enq_v = 1'b1;
    enq_bits = mk(64'h5A, 3'd1); tick();
    enq_bits = mk(64'hA5, 3'd2); tick();
    enq_v = 1'b0; reset = 1'b1; tick();
    reset = 1'b0;
    checks++;
    if (io.io_deq_valid !== 1'b0 || io.io_enq_ready !== 1'b1) begin
      errors++; $display("FAIL reset_full: got vld=%b rdy=%b want 0/1", io.io_deq_valid, io.io_enq_ready);
    end
  endtask

  task automatic test_random();
    bit stall;
    stall = 1'b0;
    for (int i = 0; i < 400; i++) begin
      // A stalled producer keeps its beat steady until it is taken.
      if (!stall) begin
        enq_v    = ($urandom_range(0, 3) != 0);
        enq_bits = mk({$urandom, $urandom}, 3'($urandom));
      end
      deq_r = ($urandom_range(0, 2) != 0);
      reset = ($urandom_range(0, 59) == 0);
      checks++;
      if (io.io_enq_ready !== (mq.size() < 2) || io.io_deq_valid !== (mq.size() > 0)) begin
        errors++; $display("FAIL rand_flags cyc %0d: got rdy=%b vld=%b occ=%0d", i, io.io_enq_ready, io.io_deq_valid, mq.size());
      end
      if (mq.size() > 0) begin
        checks++;
        if (deq_bits !== mq[0]) begin
          errors++; $display("FAIL rand_head cyc %0d: got %h want %h", i, deq_bits, mq[0]);
        end
      end
      stall = enq_v && (mq.size() == 2) && !reset;
      tick();
    end
    reset = 1'b0; enq_v = 1'b0; deq_r = 1'b1;
    tick(); tick();
    deq_r = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; enq_v = 1'b0; deq_r = 1'b0; enq_bits = '0;
    test_reset();
    test_ordering();
    test_no_flow();
    test_full_stall();
    test_stream();
    test_reset_full();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
